// File: rtl/bloon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : bloon_pkg                                              |
// | Description : Shared geometry constants, position type, FSM states   |
// |               and field helpers for the monkey fire scheduler.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package bloon_pkg;

  localparam int NUM_BLOONS  = 32;
  localparam int COORD_W     = 10;
  localparam int CENTER_OFF  = 16;

  // Field positions inside the register-file entries
  localparam int BLOON_W     = 60;
  localparam int BLOON_X_MSB = 59;
  localparam int BLOON_Y_MSB = 29;
  localparam int MONK_W      = 20;
  localparam int MONK_X_MSB  = 19;
  localparam int MONK_Y_MSB  = 9;

  // Squared distance of two 10-bit coordinates fits in 21 bits
  localparam int DIST_W      = 21;
  localparam int IDX_W       = 5;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_ISSUE  = 2'd3
  } state_t;

  // Unpack a monkey file entry {x, y}
  function automatic pos_t monk_pos(input logic [MONK_W-1:0] entry);
    pos_t p;
    p.x = entry[MONK_X_MSB -: COORD_W];
    p.y = entry[MONK_Y_MSB -: COORD_W];
    return p;
  endfunction

  // Dart aims at the sprite centre; each field wraps modulo 1024
  function automatic pos_t center_of(input pos_t p);
    pos_t c;
    c.x = p.x + COORD_W'(CENTER_OFF);
    c.y = p.y + COORD_W'(CENTER_OFF);
    return c;
  endfunction

endpackage : bloon_pkg
`default_nettype wire

// File: rtl/bloon_dist_sq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bloon_dist_sq                                          |
// | Description : Combinational squared Euclidean distance between a    |
// |               monkey and a bloon position (21-bit unsigned).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bloon_dist_sq
  import bloon_pkg::*;
(
  input  pos_t              monk,
  input  pos_t              bloon,
  output logic [DIST_W-1:0] dist_sq
);

  logic [COORD_W-1:0]   w_adx;
  logic [COORD_W-1:0]   w_ady;
  logic [2*COORD_W-1:0] w_dx2;
  logic [2*COORD_W-1:0] w_dy2;

  // Squaring discards the sign of the 11-bit difference, so only its
  // magnitude is formed; this keeps the multipliers 10x10 unsigned.
  always_comb begin
    w_adx   = (bloon.x >= monk.x) ? (bloon.x - monk.x) : (monk.x - bloon.x);
    w_ady   = (bloon.y >= monk.y) ? (bloon.y - monk.y) : (monk.y - bloon.y);
    w_dx2   = w_adx * w_adx;
    w_dy2   = w_ady * w_ady;
    dist_sq = DIST_W'(w_dx2) + DIST_W'(w_dy2);
  end

endmodule : bloon_dist_sq
`default_nettype wire

// File: rtl/monkey_fire_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : monkey_fire_scheduler                                  |
// | Description : Round-robin grants a shared nearest-bloon search to    |
// |               eligible monkeys, scans the 32-entry bloon file one    |
// |               entry per cycle and issues one dart request at a time  |
// |               over valid/ready, then loads a per-monkey cooldown.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module monkey_fire_scheduler
  import bloon_pkg::*;
#(
  parameter int NUM_MONKS       = 4,
  parameter int COOLDOWN_CYCLES = 50_000_000,
  parameter int RANGE_SQ        = 10000
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [MONK_W-1:0]    monkfileIn [NUM_MONKS],
  input  logic [NUM_MONKS-1:0] monk_valid,
  input  logic [BLOON_W-1:0]   bloonfileIn [NUM_BLOONS],
  input  logic [NUM_BLOONS-1:0] bloon_alive,
  input  logic                 dart_ready,
  output logic                 dart_valid,
  output logic [MONK_W-1:0]    dartfileDest,
  output logic [((NUM_MONKS > 1) ? $clog2(NUM_MONKS) : 1)-1:0] dart_monk,
  output logic [IDX_W-1:0]     bloon_index,
  output logic                 busy
);

  localparam int c_miw = (NUM_MONKS > 1) ? $clog2(NUM_MONKS) : 1;
  localparam int c_cw  = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [c_cw-1:0] c_cool_load = c_cw'(COOLDOWN_CYCLES);
  localparam logic [31:0]     c_range_sq  = 32'(RANGE_SQ);

  state_t             r_state;
  logic [c_miw-1:0]   r_rr_ptr;
  logic [c_miw-1:0]   r_grant;
  pos_t               r_monk_pos;
  pos_t               r_best_pos;
  logic [IDX_W-1:0]   r_scan_idx;
  logic [IDX_W-1:0]   r_best_idx;
  logic [DIST_W-1:0]  r_best_dist;
  logic               r_found;

  logic [NUM_MONKS-1:0] w_eligible;
  logic                 w_grant_vld;
  logic [c_miw-1:0]     w_grant_idx;
  logic [c_miw-1:0]     w_grant_next;
  logic                 w_grant_fire;
  int                   w_rr_idx;
  logic [BLOON_W-1:0]   w_scan_entry;
  pos_t                 w_scan_pos;
  logic [DIST_W-1:0]    w_dist;
  logic [31:0]          w_dist_ext;
  logic                 w_better;
  logic                 w_handshake;
  logic                 w_unused_bloon_bits;

  // ---------------------------------------------------------------------
  // Per-monkey cooldown counters and eligibility
  // ---------------------------------------------------------------------
  for (genvar m = 0; m < NUM_MONKS; m++) begin : g_cool
    logic [c_cw-1:0] r_cnt;

    // Load on this monkey's handshake, otherwise count down while running
    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_handshake && (dart_monk == c_miw'(m))) begin
        r_cnt <= c_cool_load;
      end else if (enable && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_eligible[m] = monk_valid[m] && (r_cnt == '0);
  end

  // ---------------------------------------------------------------------
  // Round-robin arbiter: first eligible monkey at or after r_rr_ptr
  // ---------------------------------------------------------------------
  // Rotating priority search over all monkey slots
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_rr_idx    = 0;
    for (int k = 0; k < NUM_MONKS; k++) begin
      w_rr_idx = int'(r_rr_ptr) + k;
      if (w_rr_idx >= NUM_MONKS) begin
        w_rr_idx = w_rr_idx - NUM_MONKS;
      end
      if (!w_grant_vld && w_eligible[c_miw'(w_rr_idx)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = c_miw'(w_rr_idx);
      end
    end
  end

  assign w_grant_next = (int'(w_grant_idx) == NUM_MONKS - 1) ? '0
                                                              : w_grant_idx + 1'b1;
  assign w_grant_fire = (r_state == ST_IDLE) && enable && w_grant_vld;
  assign w_handshake  = (r_state == ST_ISSUE) && dart_valid && dart_ready;

  // ---------------------------------------------------------------------
  // Scan datapath: one live bloon entry per cycle against the latched monkey
  // ---------------------------------------------------------------------
  assign w_scan_entry = bloonfileIn[r_scan_idx];
  assign w_scan_pos.x = w_scan_entry[BLOON_X_MSB -: COORD_W];
  assign w_scan_pos.y = w_scan_entry[BLOON_Y_MSB -: COORD_W];

  // The remaining bloon fields belong to other consumers of the file
  assign w_unused_bloon_bits = ^{w_scan_entry[BLOON_X_MSB-COORD_W:BLOON_Y_MSB+1],
                                 w_scan_entry[BLOON_Y_MSB-COORD_W:0]};

  bloon_dist_sq u_dist (
    .monk    (r_monk_pos),
    .bloon   (w_scan_pos),
    .dist_sq (w_dist)
  );

  assign w_dist_ext = {{(32-DIST_W){1'b0}}, w_dist};

  // Strict compares: ties keep the lower index, the range edge is excluded
  assign w_better = bloon_alive[r_scan_idx] &&
                    (w_dist_ext < c_range_sq) &&
                    (w_dist < r_best_dist);

  // ---------------------------------------------------------------------
  // Control FSM with registered dart outputs
  // ---------------------------------------------------------------------
  // IDLE -> SCAN (32 cycles) -> DECIDE -> ISSUE/IDLE; outputs latched on entry to ISSUE
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_monk_pos   <= '0;
      r_best_pos   <= '0;
      r_scan_idx   <= '0;
      r_best_idx   <= '0;
      r_best_dist  <= '1;
      r_found      <= 1'b0;
      dart_valid   <= 1'b0;
      dartfileDest <= '0;
      dart_monk    <= '0;
      bloon_index  <= '0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_fire) begin
            r_state     <= ST_SCAN;
            busy        <= 1'b1;
            r_grant     <= w_grant_idx;
            r_rr_ptr    <= w_grant_next;
            r_monk_pos  <= monk_pos(monkfileIn[w_grant_idx]);
            r_scan_idx  <= '0;
            r_best_dist <= '1;
            r_found     <= 1'b0;
          end
        end

        ST_SCAN: begin
          if (w_better) begin
            r_best_dist <= w_dist;
            r_best_idx  <= r_scan_idx;
            r_best_pos  <= w_scan_pos;
            r_found     <= 1'b1;
          end
          r_scan_idx <= r_scan_idx + 1'b1;
          if (r_scan_idx == IDX_W'(NUM_BLOONS - 1)) begin
            r_state <= ST_DECIDE;
          end
        end

        ST_DECIDE: begin
          // A monkey removed while its scan ran never fires
          if (r_found && monk_valid[r_grant]) begin
            r_state      <= ST_ISSUE;
            dart_valid   <= 1'b1;
            dartfileDest <= center_of(r_best_pos);
            dart_monk    <= r_grant;
            bloon_index  <= r_best_idx;
          end else begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_ISSUE: begin
          if (dart_ready) begin
            r_state    <= ST_IDLE;
            dart_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : monkey_fire_scheduler
`default_nettype wire

// File: tb/tb_monkey_fire_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_monkey_fire_scheduler                               |
// | Description : Scoreboard bench for monkey_fire_scheduler.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_monkey_fire_scheduler;

  localparam int NM  = 4;
  localparam int CD  = 100;
  localparam int RSQ = 10000;

  logic        Clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [19:0] monkfileIn [NM];
  logic [NM-1:0] monk_valid;
  logic [59:0] bloonfileIn [32];
  logic [31:0] bloon_alive;
  logic        dart_ready;
  logic        dart_valid;
  logic [19:0] dartfileDest;
  logic [1:0]  dart_monk;
  logic [4:0]  bloon_index;
  logic        busy;

  typedef struct {
    int          monk;
    int          idx;
    logic [19:0] dest;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 Clk = ~Clk;

  monkey_fire_scheduler #(
    .NUM_MONKS       (NM),
    .COOLDOWN_CYCLES (CD),
    .RANGE_SQ        (RSQ)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .enable       (enable),
    .monkfileIn   (monkfileIn),
    .monk_valid   (monk_valid),
    .bloonfileIn  (bloonfileIn),
    .bloon_alive  (bloon_alive),
    .dart_ready   (dart_ready),
    .dart_valid   (dart_valid),
    .dartfileDest (dartfileDest),
    .dart_monk    (dart_monk),
    .bloon_index  (bloon_index),
    .busy         (busy)
  );

  // ---------------- stimulus helpers ----------------
  task automatic clear_field();
    monk_valid  = '0;
    bloon_alive = '0;
    for (int i = 0; i < NM; i++) monkfileIn[i] = '0;
    for (int i = 0; i < 32; i++) bloonfileIn[i] = '0;
  endtask

  task automatic set_monk(input int m, input int x, input int y);
    monkfileIn[m] = {x[9:0], y[9:0]};
    monk_valid[m] = 1'b1;
  endtask

  task automatic set_bloon(input int i, input int x, input int y);
    logic [59:0] e;
    e = '0;
    e[49:30] = 20'($urandom);
    e[19:0]  = 20'($urandom);
    e[59:50] = x[9:0];
    e[29:20] = y[9:0];
    bloonfileIn[i] = e;
    bloon_alive[i] = 1'b1;
  endtask

  function automatic logic [19:0] exp_dest(input int x, input int y);
    logic [9:0] ex;
    logic [9:0] ey;
    ex = 10'(x + 16);
    ey = 10'(y + 16);
    return {ex, ey};
  endfunction

  task automatic apply_reset();
    @(negedge Clk);
    reset = 1'b1; enable = 1'b0; dart_ready = 1'b0;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
  endtask

  // Raise enable on a falling edge: the next rising edge is the grant edge
  task automatic start_game();
    @(negedge Clk);
    enable = 1'b1;
  endtask

  task automatic wait_dart(input int budget, output int cyc);
    cyc = 0;
    while (!dart_valid && cyc < budget) begin
      @(posedge Clk); #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; dart_ready = 1'b0;
    clear_field();
    repeat (2) @(posedge Clk);
    #1;
    n_checks++; if (dart_valid !== 1'b0) $display("FAIL reset_dart_valid got %b want 0", dart_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (dartfileDest !== 20'd0) $display("FAIL reset_dest got %h want 0", dartfileDest); else n_pass++;
    n_checks++; if (dart_monk !== 2'd0) $display("FAIL reset_monk got %0d want 0", dart_monk); else n_pass++;
    n_checks++; if (bloon_index !== 5'd0) $display("FAIL reset_index got %0d want 0", bloon_index); else n_pass++;
  endtask

  task automatic test_single();
    int   cyc;
    int   j;
    logic busy1;
    exp_t e;
    apply_reset();
    clear_field();
    set_monk(0, 100, 100);
    set_bloon(5, 130, 140);
    dart_ready = 1'b1;
    sb.push_back('{monk: 0, idx: 5, dest: exp_dest(130, 140)});
    start_game();
    cyc = 0; busy1 = 1'b0;
    while (!dart_valid && cyc < 60) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 1) busy1 = busy;
    end
    n_checks++; if (busy1 !== 1'b1) $display("FAIL single_busy_c1 got %b want 1", busy1); else n_pass++;
    n_checks++; if (!dart_valid || cyc != 34) $display("FAIL single_latency got valid=%b at cycle %0d want valid=1 at 34", dart_valid, cyc); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (dart_monk !== 2'(e.monk)) $display("FAIL single_monk got %0d want %0d", dart_monk, e.monk); else n_pass++;
    n_checks++; if (bloon_index !== 5'(e.idx)) $display("FAIL single_index got %0d want %0d", bloon_index, e.idx); else n_pass++;
    n_checks++; if (dartfileDest !== e.dest) $display("FAIL single_dest got %h want %h", dartfileDest, e.dest); else n_pass++;
    @(posedge Clk); #1;
    n_checks++; if (dart_valid !== 1'b0) $display("FAIL single_handshake got valid=%b want 0", dart_valid); else n_pass++;
    j = 0;
    while (!busy && j < 200) begin
      @(posedge Clk); #1;
      j++;
    end
    n_checks++; if (j < 100 || j > 102) $display("FAIL single_cooldown regrant after %0d cycles want 100..102", j); else n_pass++;
  endtask

  task automatic test_nearest_tie();
    int   cyc;
    int   nd;
    exp_t e;
    // Ties at 400 on bloons 3 and 9, 900 on 12, range edge on 1, dead close one on 15
    apply_reset();
    clear_field();
    set_monk(0, 200, 200);
    set_bloon(1, 260, 280);
    set_bloon(3, 212, 216);
    set_bloon(9, 216, 188);
    set_bloon(12, 218, 224);
    set_bloon(15, 200, 201);
    bloon_alive[15] = 1'b0;
    dart_ready = 1'b1;
    sb.push_back('{monk: 0, idx: 3, dest: exp_dest(212, 216)});
    start_game();
    wait_dart(60, cyc);
    n_checks++; if (!dart_valid) $display("FAIL tie_timeout no dart within %0d cycles", cyc); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (bloon_index !== 5'(e.idx)) $display("FAIL tie_index got %0d want %0d", bloon_index, e.idx); else n_pass++;
    n_checks++; if (dartfileDest !== e.dest) $display("FAIL tie_dest got %h want %h", dartfileDest, e.dest); else n_pass++;

    // Only a bloon at exactly the range edge: never selected
    apply_reset();
    clear_field();
    set_monk(0, 200, 200);
    set_bloon(1, 260, 280);
    dart_ready = 1'b1;
    start_game();
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge Clk); #1;
      if (dart_valid) nd++;
    end
    n_checks++; if (nd != 0) $display("FAIL edge_range got %0d dart cycles want 0", nd); else n_pass++;

    // Just inside range with negative dx/dy
    apply_reset();
    clear_field();
    set_monk(0, 200, 200);
    set_bloon(30, 101, 186);
    dart_ready = 1'b1;
    sb.push_back('{monk: 0, idx: 30, dest: exp_dest(101, 186)});
    start_game();
    wait_dart(60, cyc);
    n_checks++; if (!dart_valid) $display("FAIL inside_timeout no dart within %0d cycles", cyc); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (bloon_index !== 5'(e.idx)) $display("FAIL inside_index got %0d want %0d", bloon_index, e.idx); else n_pass++;
    n_checks++; if (dartfileDest !== e.dest) $display("FAIL inside_dest got %h want %h", dartfileDest, e.dest); else n_pass++;
  endtask

  task automatic test_round_robin();
    int   cyc;
    exp_t e;
    apply_reset();
    clear_field();
    for (int m = 0; m < NM; m++) begin
      set_monk(m, 100 + 100 * m, 300);
      set_bloon(2 + 4 * m, 110 + 100 * m, 310);
      sb.push_back('{monk: m, idx: 2 + 4 * m, dest: exp_dest(110 + 100 * m, 310)});
    end
    dart_ready = 1'b0;
    start_game();
    wait_dart(60, cyc);
    n_checks++; if (!dart_valid) $display("FAIL rr0_timeout no dart within %0d cycles", cyc); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (dart_monk !== 2'(e.monk)) $display("FAIL rr0_monk got %0d want %0d", dart_monk, e.monk); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      n_checks++;
      if (dart_valid !== 1'b1 || dart_monk !== 2'(e.monk) || bloon_index !== 5'(e.idx) || dartfileDest !== e.dest)
        $display("FAIL rr_stall_c%0d got v=%b m=%0d i=%0d d=%h want v=1 m=%0d i=%0d d=%h",
                 c, dart_valid, dart_monk, bloon_index, dartfileDest, e.monk, e.idx, e.dest);
      else n_pass++;
    end
    dart_ready = 1'b1;
    @(posedge Clk); #1;
    for (int k = 1; k < NM; k++) begin
      wait_dart(80, cyc);
      n_checks++; if (!dart_valid) $display("FAIL rr%0d_timeout no dart within %0d cycles", k, cyc); else n_pass++;
      e = sb.pop_front();
      n_checks++; if (dart_monk !== 2'(e.monk)) $display("FAIL rr%0d_monk got %0d want %0d", k, dart_monk, e.monk); else n_pass++;
      n_checks++; if (bloon_index !== 5'(e.idx) || dartfileDest !== e.dest)
        $display("FAIL rr%0d_target got i=%0d d=%h want i=%0d d=%h", k, bloon_index, dartfileDest, e.idx, e.dest);
      else n_pass++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_no_target();
    logic b1, b33, b34, b35;
    int   nd;
    apply_reset();
    clear_field();
    set_monk(0, 100, 100);
    set_bloon(4, 105, 105);
    bloon_alive[4] = 1'b0;
    set_bloon(2, 500, 500);
    set_bloon(31, 100, 200);
    dart_ready = 1'b1;
    start_game();
    nd = 0; b1 = 0; b33 = 0; b34 = 1; b35 = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge Clk); #1;
      if (dart_valid) nd++;
      if (c == 1)  b1  = busy;
      if (c == 33) b33 = busy;
      if (c == 34) b34 = busy;
      if (c == 35) b35 = busy;
    end
    n_checks++; if (nd != 0) $display("FAIL notgt_dart got %0d dart cycles want 0", nd); else n_pass++;
    n_checks++; if (b1 !== 1'b1 || b33 !== 1'b1) $display("FAIL notgt_busy_scan got c1=%b c33=%b want 1 1", b1, b33); else n_pass++;
    n_checks++; if (b34 !== 1'b0) $display("FAIL notgt_busy_c34 got %b want 0", b34); else n_pass++;
    n_checks++; if (b35 !== 1'b1) $display("FAIL notgt_regrant_c35 got busy=%b want 1", b35); else n_pass++;
  endtask

  task automatic test_removal_enable();
    int   cyc;
    int   nd;
    int   nb;
    int   j;
    logic b34;
    exp_t e;
    apply_reset();
    clear_field();
    set_monk(1, 400, 400);
    set_bloon(8, 420, 400);
    dart_ready = 1'b1;
    start_game();
    nd = 0; nb = 0; b34 = 1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge Clk); #1;
      if (c == 10) monk_valid[1] = 1'b0;
      if (dart_valid) nd++;
      if (c == 34) b34 = busy;
      if (c > 34 && busy) nb++;
    end
    n_checks++; if (nd != 0) $display("FAIL remove_dart got %0d dart cycles want 0", nd); else n_pass++;
    n_checks++; if (b34 !== 1'b0 || nb != 0) $display("FAIL remove_busy got c34=%b later=%0d want 0 0", b34, nb); else n_pass++;

    monk_valid[1] = 1'b1;
    sb.push_back('{monk: 1, idx: 8, dest: exp_dest(420, 400)});
    wait_dart(80, cyc);
    n_checks++; if (!dart_valid) $display("FAIL readd_timeout no dart within %0d cycles", cyc); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (dart_monk !== 2'(e.monk) || dartfileDest !== e.dest)
      $display("FAIL readd_dart got m=%0d d=%h want m=%0d d=%h", dart_monk, dartfileDest, e.monk, e.dest);
    else n_pass++;
    @(posedge Clk); #1;
    enable = 1'b0;
    set_monk(3, 900, 900);
    nd = 0; nb = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge Clk); #1;
      if (dart_valid) nd++;
      if (busy) nb++;
    end
    n_checks++; if (nd != 0 || nb != 0) $display("FAIL disable_grants got dart=%0d busy=%0d cycles want 0 0", nd, nb); else n_pass++;
    monk_valid[3] = 1'b0;
    enable = 1'b1;
    j = 0;
    while (!busy && j < 200) begin
      @(posedge Clk); #1;
      j++;
    end
    n_checks++; if (j < 100 || j > 102) $display("FAIL disable_freeze regrant after %0d cycles want 100..102", j); else n_pass++;
  endtask

  task automatic test_reset_issue();
    int   cyc;
    exp_t e;
    apply_reset();
    clear_field();
    set_monk(0, 100, 100);
    set_bloon(5, 130, 140);
    set_monk(2, 600, 600);
    set_bloon(20, 610, 620);
    dart_ready = 1'b0;
    sb.push_back('{monk: 0, idx: 5, dest: exp_dest(130, 140)});
    start_game();
    wait_dart(60, cyc);
    n_checks++; if (!dart_valid) $display("FAIL rstiss_timeout no dart within %0d cycles", cyc); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (dart_monk !== 2'(e.monk) || bloon_index !== 5'(e.idx))
      $display("FAIL rstiss_first got m=%0d i=%0d want m=%0d i=%0d", dart_monk, bloon_index, e.monk, e.idx);
    else n_pass++;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    #1;
    n_checks++; if ({dart_valid, busy} !== 2'b00) $display("FAIL rstiss_ctrl got valid=%b busy=%b want 0 0", dart_valid, busy); else n_pass++;
    n_checks++; if (dartfileDest !== 20'd0 || dart_monk !== 2'd0 || bloon_index !== 5'd0)
      $display("FAIL rstiss_data got d=%h m=%0d i=%0d want 0 0 0", dartfileDest, dart_monk, bloon_index);
    else n_pass++;
    repeat (2) @(negedge Clk);
    sb.push_back('{monk: 0, idx: 5, dest: exp_dest(130, 140)});
    reset = 1'b0;
    wait_dart(60, cyc);
    n_checks++; if (!dart_valid || cyc != 34) $display("FAIL rstiss_fresh_latency got valid=%b at cycle %0d want 1 at 34", dart_valid, cyc); else n_pass++;
    e = sb.pop_front();
    n_checks++; if (dart_monk !== 2'(e.monk) || dartfileDest !== e.dest)
      $display("FAIL rstiss_fresh got m=%0d d=%h want m=%0d d=%h", dart_monk, dartfileDest, e.monk, e.dest);
    else n_pass++;
    dart_ready = 1'b1;
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_nearest_tie();
    test_round_robin();
    test_no_target();
    test_removal_enable();
    test_reset_issue();
    n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d leftover entries want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_monkey_fire_scheduler
`default_nettype wire
